// File: rtl/shuffle_sched_pkg.sv
// Shared types and widths for the shuffler scheduler.
package shuffle_sched_pkg;

  localparam int unsigned WORD_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_RESP
  } state_t;

endpackage

// File: rtl/shuffle_sched_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NREQ  = 2,
  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  int unsigned j;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/shuffle_sched.sv
// Shares one Fisher-Yates shuffler between NREQ requesters with round-robin
// arbitration, a response handshake per requester and a sticky watchdog fault.
module shuffle_sched
  import shuffle_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 8191
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WORD_W-1:0] req_data,
  input  logic [NREQ*WORD_W-1:0] req_key,
  input  logic [NREQ-1:0]        req_deshuffle,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [WORD_W-1:0]      rsp_data,
  output logic                   rsp_timeout,
  output logic                   shf_en,
  output logic                   shf_deshuffle,
  output logic [WORD_W-1:0]      shf_data,
  output logic [WORD_W-1:0]      shf_key,
  input  logic                   shf_done,
  input  logic [WORD_W-1:0]      shf_result,
  output logic                   busy,
  output logic                   fault
);

  localparam int unsigned      IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned      CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t            state, state_n;
  logic [IDX_W-1:0]  rr_ptr, owner, gnt_idx, ptr_nxt;
  logic [NREQ-1:0]   gnt;
  logic [CNT_W-1:0]  wd_cnt, wd_inc;
  logic              wd_expire, grant_ok, res_tout;
  logic [WORD_W-1:0] sel_data, sel_key;
  logic              sel_desh;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign grant_ok  = (state == S_IDLE) && !fault && (|req_valid);
  assign req_ready = grant_ok ? gnt : '0;
  assign ptr_nxt   = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDX_W'(1);

  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    sel_desh = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        sel_data = req_data[k*WORD_W +: WORD_W];
        sel_key  = req_key[k*WORD_W +: WORD_W];
        sel_desh = req_deshuffle[k];
      end
    end
  end

  // Expiry is judged on the incremented value so the response lands TIMEOUT+1
  // cycles after shf_en; the counter saturates rather than wrapping.
  assign wd_inc    = (wd_cnt == CNT_MAX) ? wd_cnt : wd_cnt + CNT_W'(1);
  assign wd_expire = (wd_inc == CNT_MAX);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (grant_ok) state_n = S_LOAD;
      S_LOAD:  state_n = S_START;
      S_START: state_n = S_RUN;
      S_RUN:   if (shf_done || wd_expire) state_n = S_RESP;
      S_RESP:  if (rsp_ready[owner]) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP) rsp_valid[owner] = 1'b1;
  end

  assign shf_en      = (state == S_START);
  assign busy        = (state != S_IDLE);
  assign rsp_timeout = (state == S_RESP) && res_tout;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      shf_data      <= '0;
      shf_key       <= '0;
      shf_deshuffle <= 1'b0;
      wd_cnt        <= '0;
      rsp_data      <= '0;
      res_tout      <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (grant_ok) begin
            owner         <= gnt_idx;
            shf_data      <= sel_data;
            shf_key       <= sel_key;
            shf_deshuffle <= sel_desh;
            rr_ptr        <= ptr_nxt;
          end
        end
        S_START: wd_cnt <= '0;
        S_RUN: begin
          wd_cnt <= wd_inc;
          if (shf_done) begin
            rsp_data <= shf_result;
            res_tout <= 1'b0;
          end else if (wd_expire) begin
            rsp_data <= '0;
            res_tout <= 1'b1;
            fault    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
